// File: rtl/verdict_packet_store.sv
// verdict_packet_store
// Holds incoming AXI-Stream packets in a data FIFO until the filter lookup
// delivers a verdict for each packet. Verdicts are matched to packets in
// arrival order. Each packet is then forwarded unchanged, forwarded with its
// destination-port field rewritten (redirect), or discarded.
//
// Ports
//   axi_aclk, axi_areset       clock, asynchronous active-high reset
//   s_axis_*                   slave stream; tready = !data FIFO nearly full
//   m_axis_*                   master stream; data/tstrb/tlast are the FIFO head
//   verdict_wr_en, verdict_din push one {action[1:0], dst_port[7:0]} verdict
//   verdict_nearly_full        verdict FIFO has NEARLY_FULL_MARGIN or fewer free
//   stats_clear                synchronous clear of the packet counters
//   fwd_count, drop_count      wrapping packet counters
//   overflow_err               sticky flag for a write into a full FIFO
module verdict_packet_store #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DATA_DEPTH_BITS      = 10,
  parameter int VERDICT_DEPTH_BITS   = 6,
  parameter int NEARLY_FULL_MARGIN   = 4,
  parameter int DST_PORT_LSB         = 24
) (
  input  logic                                axi_aclk,
  input  logic                                axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  input  logic                                verdict_wr_en,
  input  logic [9:0]                          verdict_din,
  output logic                                verdict_nearly_full,
  input  logic                                stats_clear,
  output logic [31:0]                         fwd_count,
  output logic [31:0]                         drop_count,
  output logic                                overflow_err
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int EW = DW + SW + UW + 1;

  localparam int DATA_DEPTH    = 1 << DATA_DEPTH_BITS;
  localparam int VERDICT_DEPTH = 1 << VERDICT_DEPTH_BITS;

  localparam logic [DATA_DEPTH_BITS:0] DATA_FULL_LEVEL =
    (DATA_DEPTH_BITS+1)'(DATA_DEPTH);
  localparam logic [DATA_DEPTH_BITS:0] DATA_NF_LEVEL =
    (DATA_DEPTH_BITS+1)'(DATA_DEPTH - NEARLY_FULL_MARGIN);
  localparam logic [VERDICT_DEPTH_BITS:0] VERDICT_FULL_LEVEL =
    (VERDICT_DEPTH_BITS+1)'(VERDICT_DEPTH);
  localparam logic [VERDICT_DEPTH_BITS:0] VERDICT_NF_LEVEL =
    (VERDICT_DEPTH_BITS+1)'(VERDICT_DEPTH - NEARLY_FULL_MARGIN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Data FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [EW-1:0]              data_mem [DATA_DEPTH];
  logic [DATA_DEPTH_BITS-1:0] data_wr_ptr;
  logic [DATA_DEPTH_BITS-1:0] data_rd_ptr;
  logic [DATA_DEPTH_BITS:0]   data_count;
  logic                       data_empty;
  logic                       data_full;
  logic                       data_nearly_full;
  logic                       data_wr_req;
  logic                       data_push;
  logic                       data_pop;
  logic [EW-1:0]              data_head;
  logic [DW-1:0]              head_tdata;
  logic [SW-1:0]              head_tstrb;
  logic [UW-1:0]              head_tuser;
  logic                       head_tlast;

  // ---------------------------------------------------------------------------
  // Verdict FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [9:0]                    verdict_mem [VERDICT_DEPTH];
  logic [VERDICT_DEPTH_BITS-1:0] verdict_wr_ptr;
  logic [VERDICT_DEPTH_BITS-1:0] verdict_rd_ptr;
  logic [VERDICT_DEPTH_BITS:0]   verdict_count;
  logic                          verdict_empty;
  logic                          verdict_full;
  logic                          verdict_push;
  logic                          verdict_pop;
  logic [9:0]                    verdict_head;
  logic [1:0]                    head_action;

  // ---------------------------------------------------------------------------
  // Packet FSM and handshake terms
  // ---------------------------------------------------------------------------
  state_t     state;
  logic       redirect;
  logic [7:0] dst_port;
  logic       out_active;
  logic       xfer;
  logic       drop_pop;
  logic       fwd_done;
  logic       drop_done;
  logic       overflow_set;

  // FIFO status flags and the slave-side backpressure derived from the counts.
  always_comb begin
    data_empty          = (data_count == '0);
    data_full           = (data_count == DATA_FULL_LEVEL);
    data_nearly_full    = (data_count >= DATA_NF_LEVEL);
    verdict_empty       = (verdict_count == '0);
    verdict_full        = (verdict_count == VERDICT_FULL_LEVEL);
    verdict_nearly_full = (verdict_count >= VERDICT_NF_LEVEL);
    s_axis_tready       = !data_nearly_full;
  end

  // Fall-through heads of both FIFOs, unpacked into stream fields.
  always_comb begin
    data_head    = data_mem[data_rd_ptr];
    head_tlast   = data_head[0];
    head_tuser   = data_head[UW:1];
    head_tstrb   = data_head[UW+SW:UW+1];
    head_tdata   = data_head[EW-1:UW+SW+1];
    verdict_head = verdict_mem[verdict_rd_ptr];
    head_action  = verdict_head[9:8];
  end

  // Handshake, pop and write-acceptance terms. A write into a full FIFO is
  // still accepted when the same cycle pops an entry.
  always_comb begin
    out_active    = (state == ST_HEAD) || (state == ST_BODY);
    m_axis_tvalid = out_active && !data_empty;
    xfer          = m_axis_tvalid && m_axis_tready;
    drop_pop      = (state == ST_DROP) && !data_empty;
    data_pop      = xfer || drop_pop;
    fwd_done      = xfer && head_tlast;
    drop_done     = drop_pop && head_tlast;
    verdict_pop   = fwd_done || drop_done;
    data_wr_req   = s_axis_tvalid && s_axis_tready;
    data_push     = data_wr_req && (!data_full || data_pop);
    verdict_push  = verdict_wr_en && (!verdict_full || verdict_pop);
    overflow_set  = (data_wr_req && data_full && !data_pop) ||
                    (verdict_wr_en && verdict_full && !verdict_pop);
  end

  // Master stream fields; the redirect rewrite touches only the first beat.
  always_comb begin
    m_axis_tdata = head_tdata;
    m_axis_tstrb = head_tstrb;
    m_axis_tlast = head_tlast;
    m_axis_tuser = head_tuser;
    if ((state == ST_HEAD) && redirect) begin
      m_axis_tuser[DST_PORT_LSB +: 8] = dst_port;
    end else begin
      m_axis_tuser = head_tuser;
    end
  end

  // Data FIFO RAM write port (contents are intentionally not reset).
  always_ff @(posedge axi_aclk) begin
    if (data_push) begin
      data_mem[data_wr_ptr] <= {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
    end
  end

  // Verdict FIFO RAM write port (contents are intentionally not reset).
  always_ff @(posedge axi_aclk) begin
    if (verdict_push) begin
      verdict_mem[verdict_wr_ptr] <= verdict_din;
    end
  end

  // Data FIFO pointers and occupancy.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      data_wr_ptr <= '0;
      data_rd_ptr <= '0;
      data_count  <= '0;
    end else begin
      if (data_push) begin
        data_wr_ptr <= data_wr_ptr + DATA_DEPTH_BITS'(1);
      end
      if (data_pop) begin
        data_rd_ptr <= data_rd_ptr + DATA_DEPTH_BITS'(1);
      end
      case ({data_push, data_pop})
        2'b10:   data_count <= data_count + (DATA_DEPTH_BITS+1)'(1);
        2'b01:   data_count <= data_count - (DATA_DEPTH_BITS+1)'(1);
        default: data_count <= data_count;
      endcase
    end
  end

  // Verdict FIFO pointers and occupancy.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      verdict_wr_ptr <= '0;
      verdict_rd_ptr <= '0;
      verdict_count  <= '0;
    end else begin
      if (verdict_push) begin
        verdict_wr_ptr <= verdict_wr_ptr + VERDICT_DEPTH_BITS'(1);
      end
      if (verdict_pop) begin
        verdict_rd_ptr <= verdict_rd_ptr + VERDICT_DEPTH_BITS'(1);
      end
      case ({verdict_push, verdict_pop})
        2'b10:   verdict_count <= verdict_count + (VERDICT_DEPTH_BITS+1)'(1);
        2'b01:   verdict_count <= verdict_count - (VERDICT_DEPTH_BITS+1)'(1);
        default: verdict_count <= verdict_count;
      endcase
    end
  end

  // Packet FSM. The verdict stays at the FIFO head until the packet's last
  // beat leaves, so IDLE only latches a copy of the action and port.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state    <= ST_IDLE;
      redirect <= 1'b0;
      dst_port <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!verdict_empty) begin
            dst_port <= verdict_head[7:0];
            redirect <= (head_action == 2'b10);
            if ((head_action == 2'b01) || (head_action == 2'b10)) begin
              state <= ST_HEAD;
            end else begin
              state <= ST_DROP;
            end
          end
        end
        ST_HEAD: begin
          if (xfer) begin
            state <= head_tlast ? ST_IDLE : ST_BODY;
          end
        end
        ST_BODY: begin
          if (fwd_done) begin
            state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (drop_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Packet counters; a clear wins over an increment in the same cycle.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      fwd_count  <= 32'd0;
      drop_count <= 32'd0;
    end else if (stats_clear) begin
      fwd_count  <= 32'd0;
      drop_count <= 32'd0;
    end else begin
      if (fwd_done) begin
        fwd_count <= fwd_count + 32'd1;
      end
      if (drop_done) begin
        drop_count <= drop_count + 32'd1;
      end
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      overflow_err <= 1'b0;
    end else if (overflow_set) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_verdict_packet_store.sv
module tb_verdict_packet_store;

  localparam int DW      = 256;
  localparam int SW      = 32;
  localparam int UW      = 128;
  localparam int DST_LSB = 24;
  localparam int FILL    = 1024 - 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          verdict_wr_en;
  logic [9:0]    verdict_din;
  logic          verdict_nearly_full;
  logic          stats_clear;
  logic [31:0]   fwd_count;
  logic [31:0]   drop_count;
  logic          overflow_err;

  verdict_packet_store dut (
    .axi_aclk            (clk),
    .axi_areset          (rst),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tstrb        (s_axis_tstrb),
    .s_axis_tuser        (s_axis_tuser),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tready       (s_axis_tready),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tstrb        (m_axis_tstrb),
    .m_axis_tuser        (m_axis_tuser),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tready       (m_axis_tready),
    .verdict_wr_en       (verdict_wr_en),
    .verdict_din         (verdict_din),
    .verdict_nearly_full (verdict_nearly_full),
    .stats_clear         (stats_clear),
    .fwd_count           (fwd_count),
    .drop_count          (drop_count),
    .overflow_err        (overflow_err)
  );

  // Reference model state: the beats that must appear on the master side, in
  // order, and the packet counts the counters must show once traffic settles.
  beat_t      exp_q[$];
  beat_t      cur_pkt[$];
  logic [7:0] user_bytes[$];
  int         model_fwd  = 0;
  int         model_drop = 0;
  int         beats_out  = 0;
  int         n_cmp      = 0;
  int         n_err      = 0;
  int         tready_mode = 1;

  beat_t cmp_got;
  beat_t cmp_held;
  bit    cmp_held_v = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Master ready: 0 = held low, 1 = held high, 2 = random with 30% ready.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ($urandom_range(0, 99) < 30);
      endcase
    end
  end

  // Compare process: every transferred beat must be the next modelled beat,
  // and a presented beat must stay put until it is accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check(m_axis_tvalid == 1'b0, "rst_tvalid", 128'(m_axis_tvalid), 128'd0);
        cmp_held_v = 1'b0;
      end else begin
        cmp_got = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
        if (cmp_held_v) begin
          check(m_axis_tvalid && (cmp_got == cmp_held), "axi_hold",
                {cmp_got.user[31:0], cmp_got.data[63:0]},
                {cmp_held.user[31:0], cmp_held.data[63:0]});
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beats_out++;
          user_bytes.push_back(cmp_got.user[31:24]);
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_beat", {cmp_got.user[31:0], cmp_got.data[63:0]}, 128'd0);
          end else begin
            check(cmp_got == exp_q[0], "beat",
                  {31'd0, cmp_got.last, cmp_got.user[31:0], cmp_got.data[63:0]},
                  {31'd0, exp_q[0].last, exp_q[0].user[31:0], exp_q[0].data[63:0]});
            void'(exp_q.pop_front());
          end
        end
        cmp_held_v = m_axis_tvalid && !m_axis_tready;
        cmp_held   = cmp_got;
      end
    end
  end

  task automatic build_pkt(input int len, input logic [7:0] ub);
    beat_t b;
    cur_pkt.delete();
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
      b.strb = $urandom();
      b.user = {$urandom(), $urandom(), $urandom(), $urandom()};
      b.user[DST_LSB +: 8] = ub;
      b.last = (i == len - 1);
      cur_pkt.push_back(b);
    end
  endtask

  // Packet-level outcome: forward/redirect emit the packet (redirect rewrites
  // the port byte of the first beat), every other action emits nothing.
  task automatic model_pkt(input logic [1:0] act, input logic [7:0] dst);
    beat_t b;
    if (act == 2'b01 || act == 2'b10) begin
      foreach (cur_pkt[i]) begin
        b = cur_pkt[i];
        if (i == 0 && act == 2'b10) b.user[DST_LSB +: 8] = dst;
        exp_q.push_back(b);
      end
      model_fwd++;
    end else begin
      model_drop++;
    end
  endtask

  task automatic push_verdict_raw(input logic [1:0] act, input logic [7:0] dst);
    verdict_wr_en = 1'b1;
    verdict_din   = {act, dst};
    tick();
    verdict_wr_en = 1'b0;
  endtask

  task automatic push_verdict(input logic [1:0] act, input logic [7:0] dst);
    int g = 0;
    while (verdict_nearly_full && g < 20000) begin
      tick();
      g++;
    end
    if (g >= 20000) check(1'b0, "verdict_wait_timeout", 128'(g), 128'd0);
    push_verdict_raw(act, dst);
  endtask

  task automatic send_beat(input beat_t b);
    int g = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b.data;
    s_axis_tstrb  = b.strb;
    s_axis_tuser  = b.user;
    s_axis_tlast  = b.last;
    while (!s_axis_tready && g < 20000) begin
      tick();
      g++;
    end
    if (g >= 20000) check(1'b0, "tready_wait_timeout", 128'(g), 128'd0);
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_cur_beats();
    foreach (cur_pkt[i]) send_beat(cur_pkt[i]);
  endtask

  task automatic send_pkt(input logic [1:0] act, input logic [7:0] dst,
                          input int len, input logic [7:0] ub);
    build_pkt(len, ub);
    model_pkt(act, dst);
    push_verdict(act, dst);
    send_cur_beats();
  endtask

  task automatic drain(input int settle);
    int g = 0;
    while (exp_q.size() != 0 && g < 30000) begin
      tick();
      g++;
    end
    if (g >= 30000) check(1'b0, "drain_timeout", 128'(exp_q.size()), 128'd0);
    repeat (settle) tick();
  endtask

  task automatic clear_stats();
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    model_fwd  = 0;
    model_drop = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    verdict_wr_en = 1'b0;
    verdict_din   = 10'd0;
    stats_clear   = 1'b0;
    repeat (3) tick();

    // Reset state.
    check(fwd_count == 32'd0, "rst_fwd", 128'(fwd_count), 128'd0);
    check(drop_count == 32'd0, "rst_drop", 128'(drop_count), 128'd0);
    check(overflow_err == 1'b0, "rst_ovf", 128'(overflow_err), 128'd0);
    check(s_axis_tready == 1'b1, "rst_s_tready", 128'(s_axis_tready), 128'd1);
    check(verdict_nearly_full == 1'b0, "rst_vnf", 128'(verdict_nearly_full), 128'd0);
    rst = 1'b0;
    tick();

    // FORWARD one 3-beat packet with ready held high.
    b0 = beats_out;
    send_pkt(2'b01, 8'h00, 3, 8'h11);
    drain(5);
    check(fwd_count == 32'd1, "fwd3_count", 128'(fwd_count), 128'd1);
    check(beats_out - b0 == 3, "fwd3_beats", 128'(beats_out - b0), 128'd3);

    // DROP a 4-beat packet, then FORWARD a 1-beat packet.
    clear_stats();
    check(fwd_count == 32'd0, "stats_clear", 128'(fwd_count), 128'd0);
    b0 = beats_out;
    send_pkt(2'b00, 8'h00, 4, 8'h22);
    send_pkt(2'b01, 8'h00, 1, 8'h33);
    drain(5);
    check(drop_count == 32'd1, "drop_count", 128'(drop_count), 128'd1);
    check(fwd_count == 32'd1, "drop_fwd_count", 128'(fwd_count), 128'd1);
    check(beats_out - b0 == 1, "drop_beats", 128'(beats_out - b0), 128'd1);

    // REDIRECT: only the first beat carries the new port byte.
    user_bytes.delete();
    send_pkt(2'b10, 8'h40, 3, 8'h01);
    drain(5);
    check(user_bytes.size() == 3, "redir_beats", 128'(user_bytes.size()), 128'd3);
    if (user_bytes.size() == 3) begin
      check(user_bytes[0] == 8'h40, "redir_b0", 128'(user_bytes[0]), 128'h40);
      check(user_bytes[1] == 8'h01, "redir_b1", 128'(user_bytes[1]), 128'h01);
      check(user_bytes[2] == 8'h01, "redir_b2", 128'(user_bytes[2]), 128'h01);
    end

    // Verdict delayed 20 cycles after the packet is fully buffered.
    build_pkt(2, 8'h55);
    model_pkt(2'b01, 8'h00);
    send_cur_beats();
    for (int i = 0; i < 20; i++) begin
      check(m_axis_tvalid == 1'b0, "no_early_tvalid", 128'(m_axis_tvalid), 128'd0);
      tick();
    end
    push_verdict(2'b01, 8'h00);
    @(negedge clk);
    check(m_axis_tvalid == 1'b0, "verdict_plus1", 128'(m_axis_tvalid), 128'd0);
    @(negedge clk);
    check(m_axis_tvalid == 1'b1, "verdict_plus2", 128'(m_axis_tvalid), 128'd1);
    tick();
    drain(5);
    check(fwd_count == 32'(model_fwd), "delay_fwd_count", 128'(fwd_count), 128'(model_fwd));

    // 200 mixed packets against a 30% ready sink.
    clear_stats();
    tready_mode = 2;
    for (int p = 0; p < 200; p++) begin
      send_pkt(2'($urandom_range(0, 3)), 8'($urandom()), $urandom_range(1, 7), 8'($urandom()));
    end
    drain(400);
    tready_mode = 1;
    tick();
    check(fwd_count == 32'(model_fwd), "rand_fwd_count", 128'(fwd_count), 128'(model_fwd));
    check(drop_count == 32'(model_drop), "rand_drop_count", 128'(drop_count), 128'(model_drop));
    check(overflow_err == 1'b0, "rand_ovf", 128'(overflow_err), 128'd0);

    // Fill the data FIFO to its nearly-full level, then reset mid-packet.
    build_pkt(FILL, 8'h66);
    for (int i = 0; i < FILL; i++) begin
      cur_pkt[i].last = 1'b0;
      if (i == FILL - 1) begin
        check(s_axis_tready == 1'b1, "fill_minus1_tready", 128'(s_axis_tready), 128'd1);
      end
      send_beat(cur_pkt[i]);
    end
    check(s_axis_tready == 1'b0, "fill_tready", 128'(s_axis_tready), 128'd0);
    rst = 1'b1;
    exp_q.delete();
    model_fwd  = 0;
    model_drop = 0;
    tick();
    check(fwd_count == 32'd0, "midrst_fwd", 128'(fwd_count), 128'd0);
    check(drop_count == 32'd0, "midrst_drop", 128'(drop_count), 128'd0);
    check(s_axis_tready == 1'b1, "midrst_tready", 128'(s_axis_tready), 128'd1);
    rst = 1'b0;
    tick();
    b0 = beats_out;
    send_pkt(2'b01, 8'h00, 2, 8'h77);
    drain(5);
    check(beats_out - b0 == 2, "post_rst_beats", 128'(beats_out - b0), 128'd2);
    check(fwd_count == 32'd1, "post_rst_fwd", 128'(fwd_count), 128'd1);

    // Overflow the verdict FIFO with no data behind it.
    for (int i = 0; i < 64; i++) push_verdict_raw(2'b01, 8'h00);
    check(verdict_nearly_full == 1'b1, "vfifo_nf", 128'(verdict_nearly_full), 128'd1);
    check(overflow_err == 1'b0, "vfifo_full_no_ovf", 128'(overflow_err), 128'd0);
    push_verdict_raw(2'b01, 8'h00);
    check(overflow_err == 1'b1, "vfifo_ovf", 128'(overflow_err), 128'd1);
    repeat (3) tick();
    check(overflow_err == 1'b1, "ovf_sticky", 128'(overflow_err), 128'd1);
    rst = 1'b1;
    tick();
    check(overflow_err == 1'b0, "ovf_rst", 128'(overflow_err), 128'd0);
    rst = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
